// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bundle for mio_bus_ctrl.
// The master (CPU control FSM) drives the request; the slave (bus controller)
// returns read data and the one-cycle completion pulse.
//
// Handshake: a request is valid while CPU_MIO=1 and (MemRead|MemWrite)=1.
// The controller accepts it on a rising edge when it is idle, and signals
// completion with MIO_ready=1 for exactly one cycle. Data_in holds the read
// word from the edge that ends the MIO_ready cycle. The requester drops the
// request after it sees MIO_ready. A request still held after that is taken
// as a new access.
interface mio_bus_ctrl_if;
    logic        CPU_MIO;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr_bus;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;

    modport master (
        output CPU_MIO, MemRead, MemWrite, addr_bus, Data_out,
        input  Data_in, MIO_ready
    );

    modport slave (
        input  CPU_MIO, MemRead, MemWrite, addr_bus, Data_out,
        output Data_in, MIO_ready
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the CPU control FSM and the RAM/GPIO side.
// Handles one outstanding request at a time. Addresses with
// addr_bus[31:28]==4'hE decode to GPIO and all others to RAM. RAM accesses
// wait RAM_WAIT cycles before completion.
// Optional feature macro: MIO_ALIGN_CHK_EN. When it is defined, unaligned
// requests perform no access and set bus_err.
// state_dbg exposes the FSM state: 0=IDLE, 1=WAIT, 2=DONE.
module mio_bus_ctrl #(
    parameter int RAM_WAIT = 2,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_ctrl_if.slave     bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic              bus_err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter reload value on entry to WAIT. It is unused when RAM_WAIT==0.
    localparam logic [3:0] WAIT_LOAD = 4'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);
    localparam bit         HAS_WAIT  = (RAM_WAIT > 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       data_q;
    logic              wr_q;
    logic              gpio_q;
    logic              skip_q;
    logic [31:0]       data_in_q;
    logic [31:0]       gpio_out_q;
    logic              bus_err_q;

    logic req_valid;
    logic accept;
    logic req_gpio;
    logic req_conflict;
    logic req_misalign;
    logic unused_addr_bits;

    // Request qualification and decode. A request with both read and write
    // set is treated as a write.
    assign req_valid    = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
    assign accept       = (state_q == S_IDLE) & req_valid;
    assign req_gpio     = (bus.addr_bus[31:28] == 4'hE);
    assign req_conflict = bus.MemRead & bus.MemWrite;

`ifdef MIO_ALIGN_CHK_EN
    assign req_misalign = (bus.addr_bus[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // These address bits do not take part in the decode or the RAM word address.
    assign unused_addr_bits = ^{bus.addr_bus[27:RAM_AW+2], bus.addr_bus[1:0]};

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. GPIO, misaligned and zero-wait RAM requests go
    // straight to DONE. The counter is checked before it decrements, so WAIT
    // lasts RAM_WAIT cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_gpio || req_misalign || !HAS_WAIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request latches. These control the access until the controller is idle again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= 32'd0;
            wr_q   <= 1'b0;
            gpio_q <= 1'b0;
            skip_q <= 1'b0;
        end else if (accept) begin
            addr_q <= bus.addr_bus[RAM_AW+1:2];
            data_q <= bus.Data_out;
            wr_q   <= bus.MemWrite;
            gpio_q <= req_gpio;
            skip_q <= req_misalign;
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (accept && (req_conflict || req_misalign)) begin
            bus_err_q <= 1'b1;
        end
    end

    // Read-data holding register. It loads on the edge that leaves DONE and
    // holds its value through writes and skipped accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_in_q <= 32'd0;
        end else if (state_q == S_DONE && !wr_q && !skip_q) begin
            data_in_q <= gpio_q ? gpio_in : ram_dout;
        end
    end

    // GPIO output register. It loads on the edge that leaves DONE for a GPIO write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= 32'd0;
        end else if (state_q == S_DONE && wr_q && gpio_q && !skip_q) begin
            gpio_out_q <= data_q;
        end
    end

    // Strobes decode from registered state only. They last one cycle and have no glitches.
    assign bus.MIO_ready = (state_q == S_DONE);
    assign ram_we        = (state_q == S_DONE) & wr_q & ~gpio_q & ~skip_q;
    assign ram_addr      = addr_q;
    assign ram_din       = data_q;
    assign bus.Data_in   = data_in_q;
    assign gpio_out      = gpio_out_q;
    assign bus_err       = bus_err_q;
    assign state_dbg     = state_q;

`ifndef SYNTHESIS
    // Completion and write strobes never last two consecutive cycles.
    a_ready_single: assert property (@(posedge clk) disable iff (reset)
        bus.MIO_ready |=> !bus.MIO_ready);
    a_we_single: assert property (@(posedge clk) disable iff (reset)
        ram_we |=> !ram_we);
    // A RAM write strobe only appears in the completion cycle.
    a_we_in_done: assert property (@(posedge clk) disable iff (reset)
        ram_we |-> bus.MIO_ready);
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl. dut0 uses RAM_WAIT=2 and dut1 uses RAM_WAIT=0.
// The two DUTs share the request fields. Each DUT has its own CPU_MIO.
module tb_mio_bus_ctrl;

    logic clk;
    logic reset;

    logic        mio0, mio1;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_data;
    logic [31:0] gpio_in;

    logic [9:0]  ram_addr0, ram_addr1;
    logic [31:0] ram_din0, ram_din1, ram_dout0, ram_dout1;
    logic        ram_we0, ram_we1;
    logic [31:0] gpio_out0, gpio_out1;
    logic        bus_err0, bus_err1;
    logic [1:0]  state0, state1;

    int n_checks;
    int n_fail;
    int cur_sel;

    mio_bus_ctrl_if bus0();
    mio_bus_ctrl_if bus1();

    assign bus0.CPU_MIO  = mio0;
    assign bus0.MemRead  = req_rd;
    assign bus0.MemWrite = req_wr;
    assign bus0.addr_bus = req_addr;
    assign bus0.Data_out = req_data;
    assign bus1.CPU_MIO  = mio1;
    assign bus1.MemRead  = req_rd;
    assign bus1.MemWrite = req_wr;
    assign bus1.addr_bus = req_addr;
    assign bus1.Data_out = req_data;

    // RAM contents seen by both DUTs. Unlisted words return their own address.
    function automatic logic [31:0] ram_model(input logic [9:0] a);
        case (a)
            10'd4:   ram_model = 32'hDEADBEEF;
            10'd1:   ram_model = 32'h11112222;
            default: ram_model = {22'd0, a};
        endcase
    endfunction

    assign ram_dout0 = ram_model(ram_addr0);
    assign ram_dout1 = ram_model(ram_addr1);

    mio_bus_ctrl #(.RAM_WAIT(2), .RAM_AW(10)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_we(ram_we0),
        .ram_dout(ram_dout0), .gpio_in(gpio_in), .gpio_out(gpio_out0),
        .bus_err(bus_err0), .state_dbg(state0)
    );

    mio_bus_ctrl #(.RAM_WAIT(0), .RAM_AW(10)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1),
        .ram_dout(ram_dout1), .gpio_in(gpio_in), .gpio_out(gpio_out1),
        .bus_err(bus_err1), .state_dbg(state1)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request to the selected DUT. The task returns the cycle in
    // which MIO_ready appeared (1 = first cycle after the accepting edge,
    // 0 = not seen within limit). It also returns the number of ram_we cycles
    // and the RAM-side values in the ready cycle.
    task automatic do_access(input int sel, input logic mio, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data, input int limit,
                             output int lat, output int we_cnt, output logic we_at_rdy,
                             output logic [31:0] addr_at_rdy, output logic [31:0] din_at_rdy);
        logic rdy, we;
        cur_sel     = sel;
        lat         = 0;
        we_cnt      = 0;
        we_at_rdy   = 1'b0;
        addr_at_rdy = 32'd0;
        din_at_rdy  = 32'd0;
        @(negedge clk);
        mio0     = mio && (sel == 0);
        mio1     = mio && (sel == 1);
        req_rd   = rd;
        req_wr   = wr;
        req_addr = addr;
        req_data = data;
        @(posedge clk);
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (n == 1) begin
                mio0   = 1'b0;
                mio1   = 1'b0;
                req_rd = 1'b0;
                req_wr = 1'b0;
            end
            rdy = (sel == 1) ? bus1.MIO_ready : bus0.MIO_ready;
            we  = (sel == 1) ? ram_we1 : ram_we0;
            if (we) we_cnt++;
            if (rdy && lat == 0) begin
                lat         = n;
                we_at_rdy   = we;
                addr_at_rdy = (sel == 1) ? {22'd0, ram_addr1} : {22'd0, ram_addr0};
                din_at_rdy  = (sel == 1) ? ram_din1 : ram_din0;
            end
        end
    endtask

    initial begin
        int          lat, we_cnt, rdy_cnt;
        logic        we_at_rdy;
        logic [31:0] a_rdy, d_rdy;
        logic [31:0] exp_din0;

        n_checks = 0;
        n_fail   = 0;
        cur_sel  = 0;
        mio0     = 1'b0;
        mio1     = 1'b0;
        req_rd   = 1'b0;
        req_wr   = 1'b0;
        req_addr = 32'd0;
        req_data = 32'd0;
        gpio_in  = 32'hCAFE0001;
        reset    = 1'b1;

        // Reset values
        @(posedge clk);
        #1;
        check("rst_state",    {30'd0, state0}, 32'd0);
        check("rst_data_in",  bus0.Data_in, 32'd0);
        check("rst_gpio_out", gpio_out0, 32'd0);
        check("rst_ready",    {31'd0, bus0.MIO_ready}, 32'd0);
        check("rst_we",       {31'd0, ram_we0}, 32'd0);
        check("rst_bus_err",  {31'd0, bus_err0}, 32'd0);
        check("rst_ram_addr", {22'd0, ram_addr0}, 32'd0);
        check("rst_ram_din",  ram_din0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // RAM read at 0x10 with RAM_WAIT=2
        do_access(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("rd_lat",      lat, 32'd3);
        check("rd_ram_addr", a_rdy, 32'd4);
        check("rd_we_cnt",   we_cnt, 32'd0);
        check("rd_data_in",  bus0.Data_in, 32'hDEADBEEF);
        exp_din0 = 32'hDEADBEEF;

        // GPIO write of 0xA5
        do_access(0, 1'b1, 1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("gw_lat",      lat, 32'd1);
        check("gw_we_cnt",   we_cnt, 32'd0);
        check("gw_gpio_out", gpio_out0, 32'h0000_00A5);
        check("gw_data_in",  bus0.Data_in, exp_din0);

        // GPIO read
        do_access(0, 1'b1, 1'b1, 1'b0, 32'hE000_0000, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("gr_lat",     lat, 32'd1);
        check("gr_data_in", bus0.Data_in, 32'hCAFE0001);
        exp_din0 = 32'hCAFE0001;

        // Unaligned RAM read at 0x6
        do_access(0, 1'b1, 1'b1, 1'b0, 32'h0000_0006, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
`ifdef MIO_ALIGN_CHK_EN
        check("ua_lat",     lat, 32'd1);
        check("ua_data_in", bus0.Data_in, exp_din0);
        check("ua_bus_err", {31'd0, bus_err0}, 32'd1);
`else
        check("ua_lat",      lat, 32'd3);
        check("ua_ram_addr", a_rdy, 32'd1);
        check("ua_data_in",  bus0.Data_in, 32'h11112222);
        check("ua_bus_err",  {31'd0, bus_err0}, 32'd0);
        exp_din0 = 32'h11112222;
`endif

        // Reset while a RAM write is in WAIT
        @(negedge clk);
        mio0     = 1'b1;
        req_rd   = 1'b0;
        req_wr   = 1'b1;
        req_addr = 32'h0000_0020;
        req_data = 32'h0000_0099;
        @(posedge clk);
        @(negedge clk);
        mio0   = 1'b0;
        req_wr = 1'b0;
        check("rw_in_wait", {30'd0, state0}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw_state",    {30'd0, state0}, 32'd0);
        check("rw_ready",    {31'd0, bus0.MIO_ready}, 32'd0);
        check("rw_we",       {31'd0, ram_we0}, 32'd0);
        check("rw_ram_addr", {22'd0, ram_addr0}, 32'd0);
        check("rw_ram_din",  ram_din0, 32'd0);
        check("rw_data_in",  bus0.Data_in, 32'd0);
        check("rw_gpio_out", gpio_out0, 32'd0);
        check("rw_bus_err",  {31'd0, bus_err0}, 32'd0);
        exp_din0 = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        rdy_cnt = 0;
        we_cnt  = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus0.MIO_ready) rdy_cnt++;
            if (ram_we0) we_cnt++;
        end
        check("rw_no_ready", rdy_cnt, 32'd0);
        check("rw_no_we",    we_cnt, 32'd0);

        // The next request after reset completes normally
        do_access(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("pr_lat",     lat, 32'd3);
        check("pr_data_in", bus0.Data_in, 32'hDEADBEEF);
        exp_din0 = 32'hDEADBEEF;

        // Read and write both set to GPIO: handled as a write and flagged
        do_access(0, 1'b1, 1'b1, 1'b1, 32'hE000_0004, 32'h0000_0077, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("cf_lat",      lat, 32'd1);
        check("cf_gpio_out", gpio_out0, 32'h0000_0077);
        check("cf_bus_err",  {31'd0, bus_err0}, 32'd1);
        check("cf_data_in",  bus0.Data_in, exp_din0);

        // bus_err stays set across a clean access
        gpio_in = 32'h5A5A0000;
        do_access(0, 1'b1, 1'b1, 1'b0, 32'hE000_0000, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("hd_lat",     lat, 32'd1);
        check("hd_bus_err", {31'd0, bus_err0}, 32'd1);
        check("hd_data_in", bus0.Data_in, 32'h5A5A0000);
        exp_din0 = 32'h5A5A0000;

        // CPU_MIO=0 with MemRead set: no response
        do_access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 6, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("nm_lat",     lat, 32'd0);
        check("nm_data_in", bus0.Data_in, exp_din0);
        check("nm_state",   {30'd0, state0}, 32'd0);

        // RAM write with RAM_WAIT=0 on dut1
        do_access(1, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_1234, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("w0_lat",      lat, 32'd1);
        check("w0_we_cnt",   we_cnt, 32'd1);
        check("w0_we_rdy",   {31'd0, we_at_rdy}, 32'd1);
        check("w0_ram_addr", a_rdy, 32'd2);
        check("w0_ram_din",  d_rdy, 32'h0000_1234);
        check("w0_data_in",  bus1.Data_in, 32'd0);

        // RAM read with RAM_WAIT=0 on dut1
        do_access(1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 8, lat, we_cnt, we_at_rdy, a_rdy, d_rdy);
        check("r0_lat",     lat, 32'd1);
        check("r0_data_in", bus1.Data_in, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
